channel_mixer_nco: RTL and testbench
====================================

Name: channel_mixer_nco

Overview:
Parametrised successor to the channel modulator: mixes a complex baseband stream by e^{+j2πP/N}, where P is an N-entry phase accumulator (N = NUM_CHANNELS) stepped once per accepted sample.
- Adds a runtime-loadable increment, a quarter-wave sin/cos table, convergent-free round-half-up with saturation, and a fully stallable valid/ready pipeline.
- Sits between the channel filter bank output and the DAC interface.

Parameters:
WIDTH, 16, signed I/Q sample width in and out (8..24)
NUM_CHANNELS, 2048, phase steps per turn; power of two, >= 16; PHASE_BITS = $clog2(NUM_CHANNELS)
COEF_WIDTH, 16, signed sin/cos coefficient width, Q1.(COEF_WIDTH-1)

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_inph  in  WIDTH  input I, two's complement
i_quad  in  WIDTH  input Q, two's complement
i_valid  in  1  input sample valid
o_ready  out  1  block can accept input
i_phase_inc  in  PHASE_BITS  phase increment per accepted sample
i_phase_inc_valid  in  1  load i_phase_inc
o_inph  out  WIDTH  mixed I
o_quad  out  WIDTH  mixed Q
o_valid  out  1  output valid
i_ready  in  1  downstream ready

Behaviour:
- Reset: i_reset is synchronous, active-high, on i_clock. It clears o_valid, o_inph and o_quad to 0, clears the phase accumulator P and the increment register to 0, and clears all pipeline valids. It wins over every other input in the same cycle.
- Pipeline enable: en = !o_valid || i_ready. o_ready = en, a combinational function of i_ready and o_valid. The whole pipeline advances only when en = 1, with no bubbles inserted. A sample is accepted on i_valid && o_ready.
- Latency: fixed at 4 enabled cycles from acceptance to o_valid.
  - Stage 1: phase lookup.
  - Stage 2: four products.
  - Stage 3: add/sub.
  - Stage 4: round/saturate into the output registers.
- Phase: the accepted sample uses the current P. At the same edge, P <= (P + inc) mod NUM_CHANNELS, with natural wrap. P is unchanged when no sample is accepted.
- Increment load: on i_phase_inc_valid the inc register is loaded. The load is independent of o_ready and is accepted even during stall. If a sample is accepted in the same cycle, the accumulation uses the old inc; the new inc applies from the next accepted sample.
- Coefficients: c = cos(2πP/N), s = sin(2πP/N), scaled by 2^(COEF_WIDTH-1) and rounded to nearest.
  - The value +1.0 is clamped to 2^(COEF_WIDTH-1)-1; -1.0 is exact.
  - At P = 0, N/4, N/2 and 3N/4 the zero coefficient is exactly 0.
- Arithmetic:
  - out_i = I·c − Q·s and out_q = I·s + Q·c, computed at full width WIDTH+COEF_WIDTH+1.
  - Add 2^(COEF_WIDTH-2), then arithmetic shift right by COEF_WIDTH-1.
  - Saturate to [−2^(WIDTH-1), 2^(WIDTH-1)−1].
- Stall: while o_valid && !i_ready, every stage register holds and o_inph/o_quad/o_valid stay stable. No sample is dropped or duplicated.
- Reset mid-stream: in-flight samples are discarded and the next accepted sample uses P = 0.

Optional Feature:
CHANNEL_MIXER_PHASE_SYNC_EN
- Defined: adds input i_phase_sync (1 bit). An accepted sample with i_phase_sync = 1 uses P = 0, and P <= inc at that edge. i_phase_sync is ignored when no sample is accepted.
- Undefined: the port is absent and P is cleared only by i_reset.

Decomposition:
- Package channel_mixer_pkg holds:
  - the sample_t typedef (signed [WIDTH-1:0] I/Q struct);
  - the PHASE_BITS and round-constant localparam functions;
  - a saturate function.
- One sub-module, nco_quarter_lut:
  - takes P, returns registered (c, s);
  - the table has N/4+1 entries, filled at elaboration with $cos;
  - quadrant mapping is by P[PHASE_BITS-1:PHASE_BITS-2] with sign/swap;
  - 1-cycle latency and honours en.

Test Plan:
1. Idle: reset, i_ready = 1, i_valid = 0 for 100 cycles -> zero o_valid pulses.
2. inc = 0, input (1000, 0) ×8 -> eight outputs (1000, 0). The first appears 4 cycles after the first accept.
3. N = 2048, load inc = 512, input (1000, 0) ×4 -> outputs (1000, 0), (0, 1000), (−1000, 0), (0, −1000). Then load inc = 1536 in the same cycle as a sample accept and confirm the new increment takes effect one sample later.
4. Saturation: inc = 256, first accepted sample (32767, 32767) at P = 0, second at P = 256 -> second output is (0 ±1, 32767) with o_quad clamped.
5. Backpressure: 32-sample ramp, with i_ready toggled in a 3-low/2-high pattern -> 32 outputs in order, values identical to an unstalled run, and o_* stable during every stall.
6. Reset after 10 of 20 samples -> o_valid = 0 the next cycle. The next accepted sample uses P = 0 and inc = 0. With CHANNEL_MIXER_PHASE_SYNC_EN defined, a sync pulse produces the same restart without a reset.

Source files
------------

// File: rtl/channel_mixer_pkg.sv
// channel_mixer_pkg: shared types, derived-parameter helpers and the output
// saturation helper used by channel_mixer_nco and its phase-to-coefficient LUT.
package channel_mixer_pkg;

    // Default I/Q sample width and the matching sample record.
    localparam int SAMPLE_WIDTH = 16;

    typedef struct packed {
        logic signed [SAMPLE_WIDTH-1:0] inph;
        logic signed [SAMPLE_WIDTH-1:0] quad;
    } sample_t;

    // Number of phase accumulator bits for a power-of-two channel count.
    function automatic int phase_bits(input int num_channels);
        return $clog2(num_channels);
    endfunction

    // Half an LSB of the result after dropping COEF_WIDTH-1 fraction bits.
    function automatic int round_const(input int coef_width);
        return 32'sd1 << (coef_width - 2);
    endfunction

    // Clamp a wide signed value into the signed range of 'width' bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/channel_mixer_nco_lut.sv
// nco_quarter_lut: registered cos/sin lookup for a phase index P in [0, N).
// A quarter-wave cosine table of N/4+1 entries is built at elaboration; the
// two top phase bits select the quadrant, which swaps and/or negates entries.
// A negated full-scale entry maps to the exact most-negative code so that
// -1.0 is represented exactly while +1.0 is clamped to the largest code.
module nco_quarter_lut
    import channel_mixer_pkg::*;
#(
    parameter int PHASE_BITS = 11,
    parameter int COEF_WIDTH = 16
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         en,
    input  logic [PHASE_BITS-1:0]        phase,
    output logic signed [COEF_WIDTH-1:0] cos_out,
    output logic signed [COEF_WIDTH-1:0] sin_out
);

    localparam int QN       = 1 << (PHASE_BITS - 2);
    localparam int COEF_MAX = (1 << (COEF_WIDTH - 1)) - 1;
    localparam logic signed [COEF_WIDTH-1:0] C_MAX = COEF_WIDTH'(COEF_MAX);
    localparam logic signed [COEF_WIDTH-1:0] C_MIN = {1'b1, {(COEF_WIDTH-1){1'b0}}};

    logic signed [COEF_WIDTH-1:0] coef_tab_s [0:QN];
    logic [PHASE_BITS-3:0]        frac_s;
    logic [1:0]                   quadrant_s;
    logic [PHASE_BITS-2:0]        cos_idx_s;
    logic [PHASE_BITS-2:0]        sin_idx_s;
    logic signed [COEF_WIDTH-1:0] tab_cos_s;
    logic signed [COEF_WIDTH-1:0] tab_sin_s;
    logic signed [COEF_WIDTH-1:0] cos_s;
    logic signed [COEF_WIDTH-1:0] sin_s;

    // Negation that turns the clamped +1.0 code into an exact -1.0.
    function automatic logic signed [COEF_WIDTH-1:0] negate(input logic signed [COEF_WIDTH-1:0] v);
        if (v == C_MAX) begin
            return C_MIN;
        end else begin
            return -v;
        end
    endfunction

    // Quarter-wave cosine table, rounded to nearest and clamped at +1.0.
    for (genvar k = 0; k <= QN; k++) begin : g_tab
        localparam real ANGLE   = 6.283185307179586 * real'(k) / real'(4 * QN);
        localparam real SCALED  = $cos(ANGLE) * (2.0 ** (COEF_WIDTH - 1));
        localparam int  ROUNDED = $rtoi(SCALED + 0.5);
        localparam int  CLAMPED = (ROUNDED > COEF_MAX) ? COEF_MAX : ROUNDED;
        assign coef_tab_s[k] = COEF_WIDTH'(CLAMPED);
    end

    // Quadrant decode: fetch cos(frac) and sin(frac) = cos(quarter - frac), then fold.
    always_comb begin
        frac_s     = phase[PHASE_BITS-3:0];
        quadrant_s = phase[PHASE_BITS-1:PHASE_BITS-2];
        cos_idx_s  = {1'b0, frac_s};
        sin_idx_s  = (PHASE_BITS-1)'(QN) - cos_idx_s;
        tab_cos_s  = coef_tab_s[cos_idx_s];
        tab_sin_s  = coef_tab_s[sin_idx_s];
        cos_s      = tab_cos_s;
        sin_s      = tab_sin_s;
        case (quadrant_s)
            2'd0: begin
                cos_s = tab_cos_s;
                sin_s = tab_sin_s;
            end
            2'd1: begin
                cos_s = negate(tab_sin_s);
                sin_s = tab_cos_s;
            end
            2'd2: begin
                cos_s = negate(tab_cos_s);
                sin_s = negate(tab_sin_s);
            end
            default: begin
                cos_s = tab_sin_s;
                sin_s = negate(tab_cos_s);
            end
        endcase
    end

    // Coefficient register, advancing only with the pipeline enable.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cos_out <= {COEF_WIDTH{1'b0}};
            sin_out <= {COEF_WIDTH{1'b0}};
        end else if (en) begin
            cos_out <= cos_s;
            sin_out <= sin_s;
        end else begin
            cos_out <= cos_out;
            sin_out <= sin_out;
        end
    end

endmodule

// File: rtl/channel_mixer_nco.sv
// channel_mixer_nco: mixes a complex stream by e^{+j*2*pi*P/N}, P stepping by a
// runtime-loadable increment per accepted sample. Four-stage stallable pipeline
// (lookup, products, add/sub, round+saturate); o_valid rises at the fourth
// enabled edge counting the accepting edge.
// Optional build macro CHANNEL_MIXER_PHASE_SYNC_EN adds i_phase_sync, which
// restarts the phase at 0 for the accepted sample carrying it.
module channel_mixer_nco
    import channel_mixer_pkg::*;
#(
    parameter  int WIDTH        = 16,
    parameter  int NUM_CHANNELS = 2048,
    parameter  int COEF_WIDTH   = 16,
    localparam int PHASE_BITS   = phase_bits(NUM_CHANNELS)
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic signed [WIDTH-1:0] i_inph,
    input  logic signed [WIDTH-1:0] i_quad,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [PHASE_BITS-1:0]   i_phase_inc,
    input  logic                    i_phase_inc_valid,
    output logic signed [WIDTH-1:0] o_inph,
    output logic signed [WIDTH-1:0] o_quad,
    output logic                    o_valid,
    input  logic                    i_ready
`ifdef CHANNEL_MIXER_PHASE_SYNC_EN
    ,
    input  logic                    i_phase_sync
`endif
);

    localparam int PROD_W = WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + 1;
    localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(round_const(COEF_WIDTH));

    logic                          en_s;
    logic                          accept_s;
    logic                          sync_s;
    logic [PHASE_BITS-1:0]         lut_phase_s;
    logic [PHASE_BITS-1:0]         next_phase_s;
    logic [PHASE_BITS-1:0]         phase_r;
    logic [PHASE_BITS-1:0]         inc_r;

    logic                          s1_valid_r;
    logic signed [WIDTH-1:0]       s1_inph_r;
    logic signed [WIDTH-1:0]       s1_quad_r;
    logic signed [COEF_WIDTH-1:0]  cos_s;
    logic signed [COEF_WIDTH-1:0]  sin_s;

    logic                          s2_valid_r;
    logic signed [PROD_W-1:0]      p_ic_r;
    logic signed [PROD_W-1:0]      p_qs_r;
    logic signed [PROD_W-1:0]      p_is_r;
    logic signed [PROD_W-1:0]      p_qc_r;

    logic                          s3_valid_r;
    logic signed [ACC_W-1:0]       sum_i_r;
    logic signed [ACC_W-1:0]       sum_q_r;

    logic signed [ACC_W-1:0]       rnd_i_s;
    logic signed [ACC_W-1:0]       rnd_q_s;
    logic signed [WIDTH-1:0]       sat_i_s;
    logic signed [WIDTH-1:0]       sat_q_s;

    // Handshake, acceptance and next-phase selection.
    always_comb begin
        en_s     = !o_valid || i_ready;
        accept_s = i_valid && en_s;
`ifdef CHANNEL_MIXER_PHASE_SYNC_EN
        sync_s   = accept_s && i_phase_sync;
`else
        sync_s   = 1'b0;
`endif
        lut_phase_s  = phase_r;
        next_phase_s = phase_r;
        if (sync_s) begin
            lut_phase_s  = {PHASE_BITS{1'b0}};
            next_phase_s = inc_r;
        end else if (accept_s) begin
            lut_phase_s  = phase_r;
            next_phase_s = phase_r + inc_r;
        end else begin
            lut_phase_s  = phase_r;
            next_phase_s = phase_r;
        end
    end

    assign o_ready = en_s;

    // Phase accumulator and increment register; the load ignores stalls.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            phase_r <= {PHASE_BITS{1'b0}};
            inc_r   <= {PHASE_BITS{1'b0}};
        end else begin
            phase_r <= next_phase_s;
            if (i_phase_inc_valid) begin
                inc_r <= i_phase_inc;
            end else begin
                inc_r <= inc_r;
            end
        end
    end

    nco_quarter_lut #(
        .PHASE_BITS (PHASE_BITS),
        .COEF_WIDTH (COEF_WIDTH)
    ) u_lut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .en      (en_s),
        .phase   (lut_phase_s),
        .cos_out (cos_s),
        .sin_out (sin_s)
    );

    // Stages 1-3: sample alignment with the lookup, products, then add/sub.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            s1_valid_r <= 1'b0;
            s1_inph_r  <= {WIDTH{1'b0}};
            s1_quad_r  <= {WIDTH{1'b0}};
            s2_valid_r <= 1'b0;
            p_ic_r     <= {PROD_W{1'b0}};
            p_qs_r     <= {PROD_W{1'b0}};
            p_is_r     <= {PROD_W{1'b0}};
            p_qc_r     <= {PROD_W{1'b0}};
            s3_valid_r <= 1'b0;
            sum_i_r    <= {ACC_W{1'b0}};
            sum_q_r    <= {ACC_W{1'b0}};
        end else if (en_s) begin
            s1_valid_r <= accept_s;
            s1_inph_r  <= i_inph;
            s1_quad_r  <= i_quad;
            s2_valid_r <= s1_valid_r;
            p_ic_r     <= PROD_W'(s1_inph_r) * PROD_W'(cos_s);
            p_qs_r     <= PROD_W'(s1_quad_r) * PROD_W'(sin_s);
            p_is_r     <= PROD_W'(s1_inph_r) * PROD_W'(sin_s);
            p_qc_r     <= PROD_W'(s1_quad_r) * PROD_W'(cos_s);
            s3_valid_r <= s2_valid_r;
            sum_i_r    <= ACC_W'(p_ic_r) - ACC_W'(p_qs_r);
            sum_q_r    <= ACC_W'(p_is_r) + ACC_W'(p_qc_r);
        end else begin
            s1_valid_r <= s1_valid_r;
            s1_inph_r  <= s1_inph_r;
            s1_quad_r  <= s1_quad_r;
            s2_valid_r <= s2_valid_r;
            p_ic_r     <= p_ic_r;
            p_qs_r     <= p_qs_r;
            p_is_r     <= p_is_r;
            p_qc_r     <= p_qc_r;
            s3_valid_r <= s3_valid_r;
            sum_i_r    <= sum_i_r;
            sum_q_r    <= sum_q_r;
        end
    end

    // Round half up by adding half an LSB before the arithmetic shift, then clamp.
    always_comb begin
        rnd_i_s = (sum_i_r + ROUND_C) >>> (COEF_WIDTH - 1);
        rnd_q_s = (sum_q_r + ROUND_C) >>> (COEF_WIDTH - 1);
        sat_i_s = WIDTH'(saturate(64'(rnd_i_s), WIDTH));
        sat_q_s = WIDTH'(saturate(64'(rnd_q_s), WIDTH));
    end

    // Stage 4: output registers, held stable while downstream stalls.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_inph  <= {WIDTH{1'b0}};
            o_quad  <= {WIDTH{1'b0}};
        end else if (en_s) begin
            o_valid <= s3_valid_r;
            o_inph  <= sat_i_s;
            o_quad  <= sat_q_s;
        end else begin
            o_valid <= o_valid;
            o_inph  <= o_inph;
            o_quad  <= o_quad;
        end
    end

endmodule

// File: tb/tb_channel_mixer_nco.sv
// tb_channel_mixer_nco: directed, table-driven bench for channel_mixer_nco
// (WIDTH=16, NUM_CHANNELS=2048, COEF_WIDTH=16). Expected outputs are
// hand-computed; multi-cycle cases (latency, backpressure, reset, sync) are
// written out as short sequences.
module tb_channel_mixer_nco;
    import channel_mixer_pkg::*;

    logic               i_clock = 1'b0;
    logic               i_reset = 1'b1;
    logic signed [15:0] i_inph = 16'sd0;
    logic signed [15:0] i_quad = 16'sd0;
    logic               i_valid = 1'b0;
    logic               o_ready;
    logic [10:0]        i_phase_inc = 11'd0;
    logic               i_phase_inc_valid = 1'b0;
    logic signed [15:0] o_inph;
    logic signed [15:0] o_quad;
    logic               o_valid;
    logic               i_ready = 1'b1;
`ifdef CHANNEL_MIXER_PHASE_SYNC_EN
    logic               i_phase_sync = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    logic signed [15:0] got_i [$];
    logic signed [15:0] got_q [$];
    bit                 prev_stall = 1'b0;
    logic signed [15:0] prev_i = 16'sd0;
    logic signed [15:0] prev_q = 16'sd0;
    bit                 stall_stop = 1'b0;
    int                 stall_cyc = 0;

    typedef struct {
        int      pre_inc;
        int      with_inc;
        sample_t in;
        sample_t exp;
    } vec_t;

    vec_t vecs [21];

    channel_mixer_nco #(
        .WIDTH        (16),
        .NUM_CHANNELS (2048),
        .COEF_WIDTH   (16)
    ) dut (
        .i_clock           (i_clock),
        .i_reset           (i_reset),
        .i_inph            (i_inph),
        .i_quad            (i_quad),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .i_phase_inc       (i_phase_inc),
        .i_phase_inc_valid (i_phase_inc_valid),
        .o_inph            (o_inph),
        .o_quad            (o_quad),
        .o_valid           (o_valid),
        .i_ready           (i_ready)
`ifdef CHANNEL_MIXER_PHASE_SYNC_EN
        ,
        .i_phase_sync      (i_phase_sync)
`endif
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Output monitor: records handshakes and checks hold-stability during stalls.
    always @(negedge i_clock) begin
        if (!i_reset && prev_stall) begin
            check("stall_valid", int'(o_valid), 1);
            check("stall_inph", int'(o_inph), int'(prev_i));
            check("stall_quad", int'(o_quad), int'(prev_q));
        end
        if (!i_reset && o_valid && i_ready) begin
            got_i.push_back(o_inph);
            got_q.push_back(o_quad);
        end
        prev_stall = !i_reset && o_valid && !i_ready;
        prev_i     = o_inph;
        prev_q     = o_quad;
    end

    function automatic vec_t mk(input int pre, input int with_inc, input int x, input int y,
                                input int ei, input int eq);
        vec_t v;
        v.pre_inc  = pre;
        v.with_inc = with_inc;
        v.in.inph  = 16'(x);
        v.in.quad  = 16'(y);
        v.exp.inph = 16'(ei);
        v.exp.quad = 16'(eq);
        return v;
    endfunction

    task automatic do_reset();
        i_reset = 1'b1;
        i_valid = 1'b0;
        repeat (2) @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        got_i.delete();
        got_q.delete();
    endtask

    task automatic load_inc(input int v);
        i_phase_inc       = 11'(v);
        i_phase_inc_valid = 1'b1;
        @(posedge i_clock);
        #1;
        i_phase_inc_valid = 1'b0;
    endtask

    // Present one sample until accepted; optional increment load / sync in its first cycle.
    task automatic send(input int x, input int y, input int load, input bit sync);
        bit done;
        int guard;
        done  = 1'b0;
        guard = 0;
        i_inph  = 16'(x);
        i_quad  = 16'(y);
        i_valid = 1'b1;
        if (load >= 0) begin
            i_phase_inc       = 11'(load);
            i_phase_inc_valid = 1'b1;
        end
`ifdef CHANNEL_MIXER_PHASE_SYNC_EN
        i_phase_sync = sync;
`else
        if (sync) begin
            $display("note: sync requested without sync build");
        end
`endif
        while (!done && guard < 200) begin
            @(negedge i_clock);
            done = o_ready;
            @(posedge i_clock);
            #1;
            i_phase_inc_valid = 1'b0;
            guard++;
        end
        i_valid = 1'b0;
`ifdef CHANNEL_MIXER_PHASE_SYNC_EN
        i_phase_sync = 1'b0;
`endif
        if (!done) begin
            check("accept_timeout", 0, 1);
        end
    endtask

    task automatic wait_outputs(input int n, input string name);
        int guard;
        guard = 0;
        while (got_i.size() < n && guard < 1000) begin
            @(posedge i_clock);
            #1;
            guard++;
        end
        repeat (8) @(posedge i_clock);
        #1;
        check(name, got_i.size(), n);
    endtask

    initial begin
        int lat;
        int ex;
        int ey;
        int n;

        // Watchdog: never hang.
        fork
            begin
                #2000000;
                $display("FAIL watchdog actual=timeout expected=finish");
                $fatal(1, "watchdog");
            end
        join_none

        // 1. Reset state and idle.
        do_reset();
        check("rst_valid", int'(o_valid), 0);
        check("rst_inph", int'(o_inph), 0);
        check("rst_quad", int'(o_quad), 0);
        check("rst_ready", int'(o_ready), 1);
        repeat (100) @(posedge i_clock);
        #1;
        check("idle_pulses", got_i.size(), 0);

        // 2a. Latency: first output four edges counting the accepting edge.
        send(1000, 0, -1, 1'b0);
        lat = 1;
        while (!o_valid && lat < 20) begin
            @(posedge i_clock);
            #1;
            lat++;
        end
        check("latency", lat, 4);
        wait_outputs(1, "lat_count");
        if (got_i.size() >= 1) begin
            check("lat_inph", int'(got_i[0]), 1000);
            check("lat_quad", int'(got_q[0]), 0);
        end

        // 2-4. Table-driven vectors (inc=0 run, quadrant steps, inc change, saturation).
        for (int k = 0; k < 8; k++) vecs[k] = mk(-1, -1, 1000, 0, 1000, 0);
        vecs[8]  = mk(512,  -1,   1000,   0,   1000,    0);
        vecs[9]  = mk(-1,   -1,   1000,   0,      0, 1000);
        vecs[10] = mk(-1,   -1,   1000,   0,  -1000,    0);
        vecs[11] = mk(-1,   -1,   1000,   0,      0, -1000);
        vecs[12] = mk(-1,   1536, 1000,   0,   1000,    0);
        vecs[13] = mk(-1,   -1,   1000,   0,      0, 1000);
        vecs[14] = mk(-1,   -1,   1000,   0,   1000,    0);
        vecs[15] = mk(-1,   -1,   1000,   0,      0, -1000);
        vecs[16] = mk(1024, -1,   1000,   0,  -1000,    0);
        vecs[17] = mk(256,  -1,   32767,  32767,  32766, 32766);
        vecs[18] = mk(-1,   -1,   32767,  32767,  0,     32767);
        vecs[19] = mk(-1,   -1,   -32768, -32768, 32767, -32767);
        vecs[20] = mk(-1,   -1,   -32768, 32767,  1,     -32768);

        do_reset();
        for (int k = 0; k < 21; k++) begin
            if (vecs[k].pre_inc >= 0) load_inc(vecs[k].pre_inc);
            send(int'(vecs[k].in.inph), int'(vecs[k].in.quad), vecs[k].with_inc, 1'b0);
        end
        wait_outputs(21, "vec_count");
        n = (got_i.size() < 21) ? got_i.size() : 21;
        for (int k = 0; k < n; k++) begin
            check($sformatf("vec%0d_inph", k), int'(got_i[k]), int'(vecs[k].exp.inph));
            check($sformatf("vec%0d_quad", k), int'(got_q[k]), int'(vecs[k].exp.quad));
        end

        // 5. Backpressure: 32-sample ramp with inc=512, i_ready 3 low / 2 high.
        do_reset();
        load_inc(512);
        stall_stop = 1'b0;
        stall_cyc  = 0;
        fork
            begin
                while (!stall_stop) begin
                    @(posedge i_clock);
                    #1;
                    i_ready = ((stall_cyc % 5) >= 3);
                    stall_cyc++;
                end
                i_ready = 1'b1;
            end
        join_none
        for (int k = 0; k < 32; k++) send(k * 37 - 500, 300 - k * 23, -1, 1'b0);
        wait_outputs(32, "bp_count");
        stall_stop = 1'b1;
        repeat (3) @(posedge i_clock);
        #1;
        n = (got_i.size() < 32) ? got_i.size() : 32;
        for (int k = 0; k < n; k++) begin
            case (k % 4)
                0:       begin ex = k * 37 - 500;    ey = 300 - k * 23;    end
                1:       begin ex = -(300 - k * 23); ey = k * 37 - 500;    end
                2:       begin ex = -(k * 37 - 500); ey = -(300 - k * 23); end
                default: begin ex = 300 - k * 23;    ey = -(k * 37 - 500); end
            endcase
            check($sformatf("bp%0d_inph", k), int'(got_i[k]), ex);
            check($sformatf("bp%0d_quad", k), int'(got_q[k]), ey);
        end

        // 6. Reset after 10 of 20 samples: pipeline flushed, P and inc back to 0.
        do_reset();
        load_inc(512);
        for (int k = 0; k < 10; k++) send(100 + k, -50 - k, -1, 1'b0);
        i_reset = 1'b1;
        @(posedge i_clock);
        #1;
        check("midrst_valid", int'(o_valid), 0);
        check("midrst_inph", int'(o_inph), 0);
        i_reset = 1'b0;
        got_i.delete();
        got_q.delete();
        for (int k = 10; k < 20; k++) send(100 + k, -50 - k, -1, 1'b0);
        wait_outputs(10, "midrst_count");
        n = (got_i.size() < 10) ? got_i.size() : 10;
        for (int k = 0; k < n; k++) begin
            check($sformatf("midrst%0d_inph", k), int'(got_i[k]), 110 + k);
            check($sformatf("midrst%0d_quad", k), int'(got_q[k]), -60 - k);
        end

`ifdef CHANNEL_MIXER_PHASE_SYNC_EN
        // Sync pulse restarts the phase at 0 without a reset.
        load_inc(512);
        got_i.delete();
        got_q.delete();
        send(1000, 0, -1, 1'b0);
        send(1000, 0, -1, 1'b0);
        send(1000, 0, -1, 1'b1);
        send(1000, 0, -1, 1'b0);
        wait_outputs(4, "sync_count");
        if (got_i.size() >= 4) begin
            check("sync0_inph", int'(got_i[0]), 1000);
            check("sync1_quad", int'(got_q[1]), 1000);
            check("sync2_inph", int'(got_i[2]), 1000);
            check("sync2_quad", int'(got_q[2]), 0);
            check("sync3_inph", int'(got_i[3]), 0);
            check("sync3_quad", int'(got_q[3]), 1000);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
